// File: rtl/iopad_bank.sv
// GPIO pad bank: registered pad drive with push-pull/open-drain modes,
// plus a synchronised, glitch-filtered input path with edge pulses.
module iopad_bank #(
  parameter int DW       = 8,
  parameter int SYNC_STG = 2,
  parameter int FILT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     dout,
  input  logic [DW-1:0]     dout_en,
  input  logic [DW-1:0]     od_mode,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [DW-1:0]     pad_i,
  output logic [DW-1:0]     pad_o,
  output logic [DW-1:0]     pad_oe,
  output logic [DW-1:0]     din,
  output logic [DW-1:0]     rise,
  output logic [DW-1:0]     fall
);

  logic [DW-1:0]     sync_q [SYNC_STG];
  logic [FILT_W-1:0] cnt    [DW];
  logic [FILT_W-1:0] cnt_nx [DW];
  logic [DW-1:0]     s;
  logic [DW-1:0]     din_nx;
  logic [FILT_W-1:0] thr;

  assign s   = sync_q[SYNC_STG-1];
  assign thr = filt_len - FILT_W'(1);

  // >= against N-1 lets a shortened filter length commit immediately
  always_comb begin
    din_nx = din;
    for (int i = 0; i < DW; i++) begin
      cnt_nx[i] = cnt[i];
      if (filt_len == '0) begin
        din_nx[i] = s[i];
        cnt_nx[i] = '0;
      end else if (s[i] == din[i]) begin
        cnt_nx[i] = '0;
      end else if (cnt[i] >= thr) begin
        din_nx[i] = s[i];
        cnt_nx[i] = '0;
      end else begin
        cnt_nx[i] = cnt[i] + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_o  <= '0;
      pad_oe <= '0;
      din    <= '0;
      rise   <= '0;
      fall   <= '0;
      for (int k = 0; k < SYNC_STG; k++) sync_q[k] <= '0;
      for (int i = 0; i < DW; i++) cnt[i] <= '0;
    end else begin
      pad_o  <= dout & ~od_mode;
      pad_oe <= dout_en & ~(od_mode & dout);
      sync_q[0] <= pad_i;
      for (int k = 1; k < SYNC_STG; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < DW; i++) cnt[i] <= cnt_nx[i];
      din  <= din_nx;
      rise <= din_nx & ~din;
      fall <= ~din_nx & din;
    end
  end

endmodule

// File: tb/tb_iopad_bank.sv
// Directed bench for iopad_bank: cycle-by-cycle model comparison
// plus literal expectations for the documented scenarios.
module tb_iopad_bank;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int FW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] dout, dout_en, od_mode, pad_i;
  logic [FW-1:0] filt_len;
  logic [DW-1:0] pad_o, pad_oe, din, rise, fall;

  iopad_bank #(.DW(DW), .SYNC_STG(SS), .FILT_W(FW)) dut (
    .clk(clk), .rst(rst), .dout(dout), .dout_en(dout_en),
    .od_mode(od_mode), .filt_len(filt_len), .pad_i(pad_i),
    .pad_o(pad_o), .pad_oe(pad_oe), .din(din),
    .rise(rise), .fall(fall)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 0;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %h, want %h", name, $time, act, exp);
  endtask

  // Model: pad_i is seen by the filter SS edges after it is sampled;
  // din follows once the difference has persisted max(N,1) cycles.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_pad_o, m_pad_oe, m_din, m_rise, m_fall;
  int run [DW];

  always @(posedge clk) begin
    logic [DW-1:0] sv;
    int need;
    if (rst) begin
      q = {};
      for (int k = 0; k < SS; k++) q.push_back('0);
      m_pad_o = 0; m_pad_oe = 0; m_din = 0; m_rise = 0; m_fall = 0;
      for (int i = 0; i < DW; i++) run[i] = 0;
    end else begin
      sv = q[0];
      void'(q.pop_front());
      q.push_back(pad_i);
      need = (filt_len == 0) ? 1 : int'(filt_len);
      m_rise = 0;
      m_fall = 0;
      for (int i = 0; i < DW; i++) begin
        if (od_mode[i]) begin
          m_pad_o[i]  = 1'b0;
          m_pad_oe[i] = dout_en[i] && !dout[i];
        end else begin
          m_pad_o[i]  = dout[i];
          m_pad_oe[i] = dout_en[i];
        end
        if (sv[i] !== m_din[i]) begin
          run[i]++;
          if (run[i] >= need) begin
            m_din[i] = sv[i];
            run[i] = 0;
            if (sv[i]) m_rise[i] = 1'b1;
            else m_fall[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_pad_o", pad_o, m_pad_o);
      chk("model_pad_oe", pad_oe, m_pad_oe);
      chk("model_din", din, m_din);
      chk("model_rise", rise, m_rise);
      chk("model_fall", fall, m_fall);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1; dout = 0; dout_en = 0; od_mode = 0;
    pad_i = 0; filt_len = 0;
    step();
    chk("rst_pad_o", pad_o, 8'h00);
    chk("rst_pad_oe", pad_oe, 8'h00);
    chk("rst_din", din, 8'h00);
    chk("rst_rise", rise, 8'h00);
    chk("rst_fall", fall, 8'h00);
    check_en = 1;
    rst = 0;

    // output path
    od_mode = 8'h00; dout = 8'hA5; dout_en = 8'hFF;
    step();
    chk("pp_pad_o", pad_o, 8'hA5);
    chk("pp_pad_oe", pad_oe, 8'hFF);
    od_mode = 8'hFF;
    step();
    chk("od_pad_o", pad_o, 8'h00);
    chk("od_pad_oe", pad_oe, 8'h5A);

    // bypass filter latency
    filt_len = 0;
    pad_i = 8'h01;
    step(2);
    chk("byp_din_e2", din, 8'h00);
    step();
    chk("byp_din_e3", din, 8'h01);
    chk("byp_rise_e3", rise, 8'h01);
    chk("byp_fall_e3", fall, 8'h00);
    step();
    chk("byp_rise_e4", rise, 8'h00);
    chk("byp_fall_e4", fall, 8'h00);
    pad_i = 8'h00;
    step(5);

    // glitch of 3 cycles rejected at N=4
    filt_len = 4;
    pad_i[3] = 1'b1;
    step(3);
    pad_i[3] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("glitch_din3", 8'(din[3]), 8'h00);
      chk("glitch_ev3", 8'({rise[3], fall[3]}), 8'h00);
    end
    pad_i[3] = 1'b1;
    step(5);
    chk("f4_din3_e5", 8'(din[3]), 8'h00);
    step();
    chk("f4_din3_e6", 8'(din[3]), 8'h01);
    chk("f4_rise3_e6", 8'(rise[3]), 8'h01);
    step();
    chk("f4_rise3_e7", 8'(rise[3]), 8'h00);
    pad_i[3] = 1'b0;
    step(8);

    // shrinking filt_len mid-count
    filt_len = 8;
    pad_i[1] = 1'b1;
    step(5);
    chk("shrink_din1_pre", 8'(din[1]), 8'h00);
    filt_len = 2;
    step();
    chk("shrink_din1", 8'(din[1]), 8'h01);
    chk("shrink_rise1", 8'(rise[1]), 8'h01);
    pad_i[1] = 1'b0;
    step(6);
    chk("shrink_din_low", din, 8'h00);

    // reset mid-filter
    filt_len = 3;
    pad_i = 8'hFF;
    step(3);
    rst = 1;
    step();
    chk("mrst_pad_o", pad_o, 8'h00);
    chk("mrst_pad_oe", pad_oe, 8'h00);
    chk("mrst_din", din, 8'h00);
    chk("mrst_ev", rise | fall, 8'h00);
    rst = 0;
    step(4);
    chk("mrst_din_e4", din, 8'h00);
    step();
    chk("mrst_din_e5", din, 8'hFF);
    chk("mrst_rise_e5", rise, 8'hFF);
    step();
    chk("mrst_rise_e6", rise, 8'h00);

    // toggling channel 7 every cycle at N=2
    filt_len = 2;
    for (int c = 0; c < 20; c++) begin
      pad_i[7] = ~pad_i[7];
      step();
      chk("tog_din", din, 8'hFF);
      chk("tog_ev", rise | fall, 8'h00);
    end

    pad_i = 8'hFF;
    step(4);
    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iopad_bank.md
Name: iopad_bank

Overview:
- Parametrised, multi-channel successor to the single-pad iopad: a bank of DW independent bidirectional pad channels.
- Output path: registered pad drive with per-channel output enable and per-channel push-pull / open-drain mode.
- Input path: multi-stage synchroniser, programmable digital glitch filter, and registered rise/fall event pulses.
- Sits between core logic and the pad ring; one instance per GPIO bank.

Parameters:
- DW, 8, number of pad channels (>=1).
- SYNC_STG, 2, input synchroniser depth in flops (>=2).
- FILT_W, 4, width of filter length control and per-channel filter counter.

Ports:
- clk  input  1  bank clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- dout  input  DW  core output data per channel.
- dout_en  input  DW  core output enable per channel (1 = drive).
- od_mode  input  DW  per channel: 1 = open-drain, 0 = push-pull.
- filt_len  input  FILT_W  filter length N, shared by all channels; 0 = bypass.
- pad_i  input  DW  asynchronous pad input level.
- pad_o  output  DW  pad output data.
- pad_oe  output  DW  pad output enable (1 = driving).
- din  output  DW  synchronised, filtered input level.
- rise  output  DW  one-cycle pulse on a filtered 0->1 change.
- fall  output  DW  one-cycle pulse on a filtered 1->0 change.

Behaviour:
- Reset (rst=1 at an edge) clears every flop:
  - pad_o=0, pad_oe=0 (all pads high-Z).
  - din=0, rise=0, fall=0.
  - Synchroniser stages = 0; filter counters = 0.
  - rst wins over any simultaneous input; reset mid-operation discards in-flight filter counts.
- Output path, 1-cycle latency, per channel i:
  - push-pull (od_mode[i]=0): pad_o[i]<=dout[i]; pad_oe[i]<=dout_en[i].
  - open-drain (od_mode[i]=1): pad_o[i]<=0; pad_oe[i]<=dout_en[i] & ~dout[i].
  - Simultaneous changes of dout, dout_en and od_mode all take effect on the same edge. No intermediate state is visible.
- Synchroniser:
  - pad_i[i] is shifted through SYNC_STG flops; s[i] is the last stage.
  - No other logic samples pad_i directly.
- Filter (per channel; counter cnt[i] is FILT_W bits; N = filt_len):
  - N=0: din[i]<=s[i] every cycle; cnt[i] held at 0.
  - N>=1, s[i]==din[i]: cnt[i]<=0.
  - N>=1, s[i]!=din[i], cnt[i]>=N-1: din[i]<=s[i]; cnt[i]<=0.
  - N>=1, s[i]!=din[i], otherwise: cnt[i]<=cnt[i]+1.
  - A change therefore needs N consecutive differing cycles. N=0 and N=1 behave identically.
  - Using >= means a decrease of filt_len mid-count commits on the next differing cycle. The counter never wraps.
  - Glitches shorter than N cycles (measured at s) do not change din and produce no pulse.
- Latency: a pad_i step sampled at edge k appears on din at edge k+SYNC_STG-1+max(N,1). A stable step is visible after exactly SYNC_STG+max(N,1) edges.
- Events:
  - rise[i] and fall[i] are flops updated on the same edge as din.
  - rise[i]=1 for exactly the one cycle in which din[i] first reads 1 after reading 0; fall[i] is the mirror case.
  - Otherwise both are 0; they are never high together.
  - Reset release with pad held high: rise fires after the normal latency (din starts from 0).
- Channels are fully independent; no cross-channel interaction except the shared filt_len.

Test Plan:
1. Reset, then DW=8, od_mode=0x00, dout=0xA5, dout_en=0xFF, one edge -> pad_o=0xA5, pad_oe=0xFF. Set od_mode=0xFF -> next edge pad_o=0x00, pad_oe=0x5A.
2. filt_len=0, SYNC_STG=2, pad_i[0] 0->1 before edge 1 -> din[0]=1 and rise[0]=1 after edge 3; rise[0]=0 after edge 4; fall stays 0.
3. filt_len=4, pad_i[3] high for 3 cycles then low -> din[3] stays 0, no rise/fall. Held high 4+ cycles -> din[3]=1 after 2+4=6 edges, with a single rise pulse.
4. filt_len=8, pad_i[1] held high for 5 cycles, then filt_len set to 2 -> din[1] updates on the next edge; no counter wrap.
5. Hold pad_i=0xFF with filt_len=3, pulse rst for 1 cycle mid-filter -> all outputs 0 on the reset edge. After release, din=0xFF and rise=0xFF for one cycle, 2+3=5 edges after release.
6. Toggle pad_i[7] every cycle with filt_len=2 for 20 cycles -> din[7] constant, rise[7]/fall[7] never asserted; other channels unaffected.
